particle_draw: RTL and testbench

- Drawing stage directly upstream of particle_rom. It drives the ROM address and consumes the ROM pixel.
- Sits in the VGA pixel chain, between the previous drawing stage and the next one.
- On a launch pulse it spawns one 64x64 particle sprite and moves it once per frame for a bounded lifetime.
- It overlays non-transparent sprite pixels on the incoming stream and delays all timing signals to match.

---
 rtl/particle_pkg.sv | 37 +++
 rtl/particle_motion.sv | 124 ++++++++++++
 rtl/particle_draw.sv | 144 ++++++++++++++
 tb/tb_particle_draw.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/particle_pkg.sv
// particle_pkg: shared types and constants for the particle drawing stage.
//   SPRITE_SIZE  - sprite edge length in pixels (64x64 sprite)
//   PIPE_LAT     - fixed latency of the overlay pipeline in clocks
//   state_t      - particle lifecycle states
//   vga_timing_t - bundle of VGA timing signals carried down the pipeline
package particle_pkg;

  localparam int SPRITE_SIZE = 64;
  localparam int PIPE_LAT    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FLY  = 1'b1
  } state_t;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
  } vga_timing_t;

  // Offset of a beam coordinate from a sprite origin, widened so that a beam
  // left of / above the origin shows up as bit 12 set instead of wrapping.
  function automatic logic [12:0] sprite_offset(input logic [10:0] beam,
                                                input logic [11:0] origin);
    return {2'b00, beam} - {1'b0, origin};
  endfunction

  // Signed 8-bit increment that sticks at +127.
  function automatic logic [7:0] sat_inc_s8(input logic [7:0] v);
    return (v == 8'h7F) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/particle_motion.sv
// particle_motion: particle lifecycle FSM, per-frame position/velocity update,
// lifetime counter and frame-tick (vblank rising edge) detection.
// Optional feature macro: PARTICLE_GRAVITY_EN (vy += 1 per frame, saturating).
//   clk60MHz  in   pixel clock
//   rst       in   synchronous active-high reset
//   launch    in   single-cycle spawn request
//   launch_x  in   spawn x (sprite top-left)
//   launch_y  in   spawn y (sprite top-left)
//   vblnk_in  in   vertical blank, rising edge is the frame tick
//   x, y      out  current sprite top-left corner
//   alive     out  high while the particle is flying
//
// state | meaning
// IDLE  | no particle; waiting for launch
// FLY   | particle alive; moves once per frame tick until lifetime/edge kill
module particle_motion
  import particle_pkg::*;
#(
  parameter int              H_ACTIVE = 800,
  parameter int              V_ACTIVE = 600,
  parameter int              LIFETIME = 60,
  parameter logic signed [7:0] VX_INIT = 8'sd3,
  parameter logic signed [7:0] VY_INIT = -8'sd4
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        launch,
  input  logic [11:0] launch_x,
  input  logic [11:0] launch_y,
  input  logic        vblnk_in,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        alive
);

  localparam logic signed [12:0] H_LIM = 13'(H_ACTIVE);
  localparam logic signed [12:0] V_LIM = 13'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        vblnk_q, vblnk_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [7:0]  vx_q, vx_d;
  logic [7:0]  vy_q, vy_d;
  logic [7:0]  frames_q, frames_d;

  logic              tick;
  logic [7:0]        frames_dec;
  logic signed [12:0] nx;
  logic signed [12:0] ny;
  logic              kill;

  always_comb begin
    state_d  = state_q;
    vblnk_d  = vblnk_in;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    frames_d = frames_q;

    tick       = vblnk_in & ~vblnk_q;
    frames_dec = frames_q - 8'd1;
    nx         = $signed({1'b0, x_q}) + $signed({{5{vx_q[7]}}, vx_q});
    ny         = $signed({1'b0, y_q}) + $signed({{5{vy_q[7]}}, vy_q});
    kill       = (frames_dec == 8'd0) || nx[12] || ny[12] ||
                 (nx >= H_LIM) || (ny >= V_LIM);

    case (state_q)
      IDLE: begin
        // A tick coinciding with launch is ignored: the particle starts moving
        // on the first tick seen while in FLY.
        if (launch) begin
          x_d      = launch_x;
          y_d      = launch_y;
          vx_d     = VX_INIT;
          vy_d     = VY_INIT;
          frames_d = 8'(LIFETIME);
          state_d  = FLY;
        end
      end
      FLY: begin
        if (tick) begin
          frames_d = frames_dec;
          if (kill) begin
            state_d = IDLE;
          end else begin
            x_d = nx[11:0];
            y_d = ny[11:0];
`ifdef PARTICLE_GRAVITY_EN
            vy_d = sat_inc_s8(vy_q);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q  <= IDLE;
      vblnk_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      vblnk_q  <= vblnk_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      frames_q <= frames_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign alive = (state_q == FLY);

endmodule

// File: rtl/particle_draw.sv
// particle_draw: VGA drawing stage that overlays one moving 64x64 particle
// sprite (pixels fetched from particle_rom) onto the incoming pixel stream.
// Fixed 3-cycle latency on all timing and colour signals.
// Optional feature macro: PARTICLE_GRAVITY_EN (handled in particle_motion).
//   clk60MHz, rst          pixel clock, synchronous active-high reset
//   launch, launch_x/_y    spawn request and sprite top-left position
//   *count_in, *sync_in, *blnk_in, rgb_in   upstream pixel stream
//   rom_addr / rom_rgb     particle_rom address out, pixel back 1 cycle later
//   *count_out, *sync_out, *blnk_out, rgb_out  downstream pixel stream
//   busy                   high while a particle is alive
module particle_draw
  import particle_pkg::*;
#(
  parameter int                H_ACTIVE        = 800,
  parameter int                V_ACTIVE        = 600,
  parameter int                LIFETIME        = 60,
  parameter logic signed [7:0] VX_INIT         = 8'sd3,
  parameter logic signed [7:0] VY_INIT         = -8'sd4,
  parameter logic [11:0]       TRANSPARENT_RGB = 12'h000
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        launch,
  input  logic [11:0] launch_x,
  input  logic [11:0] launch_y,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        busy
);

  logic [11:0] x;
  logic [11:0] y;
  logic        alive;

  particle_motion #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .LIFETIME (LIFETIME),
    .VX_INIT  (VX_INIT),
    .VY_INIT  (VY_INIT)
  ) u_motion (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .launch   (launch),
    .launch_x (launch_x),
    .launch_y (launch_y),
    .vblnk_in (vblnk_in),
    .x        (x),
    .y        (y),
    .alive    (alive)
  );

  vga_timing_t tin;
  vga_timing_t s1_q, s1_d;
  vga_timing_t s2_q, s2_d;
  vga_timing_t s3_q, s3_d;
  logic [11:0] rgb1_q, rgb1_d;
  logic [11:0] rgb2_q, rgb2_d;
  logic [11:0] rgb3_q, rgb3_d;
  logic        hit1_q, hit1_d;
  logic        hit2_q, hit2_d;
  logic [11:0] rom_addr_q, rom_addr_d;

  logic [12:0] dx;
  logic [12:0] dy;
  logic        blank2;

  always_comb begin
    tin.vcount = vcount_in;
    tin.hcount = hcount_in;
    tin.vsync  = vsync_in;
    tin.hsync  = hsync_in;
    tin.vblnk  = vblnk_in;
    tin.hblnk  = hblnk_in;

    // Stage 1: hit test and ROM address. Bits [12:6] clear means the offset
    // is in 0..63 and the beam is not left of / above the origin.
    dx     = sprite_offset(hcount_in, x);
    dy     = sprite_offset(vcount_in, y);
    hit1_d = alive && (dx[12:6] == 7'd0) && (dy[12:6] == 7'd0);
    rom_addr_d = hit1_d ? {dy[5:0], dx[5:0]} : 12'h000;
    s1_d   = tin;
    rgb1_d = rgb_in;

    // Stage 2: wait for the ROM pixel.
    s2_d   = s1_q;
    rgb2_d = rgb1_q;
    hit2_d = hit1_q;

    // Stage 3: overlay, never during blanking.
    blank2 = s2_q.hblnk | s2_q.vblnk;
    s3_d   = s2_q;
    rgb3_d = (hit2_q && !blank2 && (rom_rgb != TRANSPARENT_RGB)) ? rom_rgb : rgb2_q;
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      rgb1_q     <= '0;
      rgb2_q     <= '0;
      rgb3_q     <= '0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      rgb1_q     <= rgb1_d;
      rgb2_q     <= rgb2_d;
      rgb3_q     <= rgb3_d;
      hit1_q     <= hit1_d;
      hit2_q     <= hit2_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign vcount_out = s3_q.vcount;
  assign hcount_out = s3_q.hcount;
  assign vsync_out  = s3_q.vsync;
  assign hsync_out  = s3_q.hsync;
  assign vblnk_out  = s3_q.vblnk;
  assign hblnk_out  = s3_q.hblnk;
  assign rgb_out    = rgb3_q;
  assign busy       = alive;

endmodule

// File: tb/tb_particle_draw.sv
module tb_particle_draw;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch;
  logic [11:0] launch_x, launch_y;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] rom_addr;
  logic [11:0] rom_rgb = 12'h000;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;
  logic        busy;

  // Second instance with a short lifetime, sharing all inputs.
  logic [11:0] b_rom_addr;
  logic [10:0] b_vcount_out, b_hcount_out;
  logic        b_vsync_out, b_hsync_out, b_vblnk_out, b_hblnk_out;
  logic [11:0] b_rgb_out;
  logic        b_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  particle_draw dut (
    .clk60MHz(clk), .rst(rst), .launch(launch), .launch_x(launch_x), .launch_y(launch_y),
    .vcount_in(vcount_in), .hcount_in(hcount_in), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .vblnk_in(vblnk_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .vcount_out(vcount_out), .hcount_out(hcount_out), .vsync_out(vsync_out),
    .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .busy(busy)
  );

  particle_draw #(.LIFETIME(4)) dut_short (
    .clk60MHz(clk), .rst(rst), .launch(launch), .launch_x(launch_x), .launch_y(launch_y),
    .vcount_in(vcount_in), .hcount_in(hcount_in), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .vblnk_in(vblnk_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
    .rom_addr(b_rom_addr), .rom_rgb(12'h000),
    .vcount_out(b_vcount_out), .hcount_out(b_hcount_out), .vsync_out(b_vsync_out),
    .hsync_out(b_hsync_out), .vblnk_out(b_vblnk_out), .hblnk_out(b_hblnk_out),
    .rgb_out(b_rgb_out), .busy(b_busy)
  );

  // ROM model: registered, one cycle latency; address 0x3C0 holds transparent black.
  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    return (a == 12'h3C0) ? 12'h000 : (a ^ 12'h800);
  endfunction

  always @(posedge clk) rom_rgb <= rom_fn(rom_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    launch = 0; launch_x = 0; launch_y = 0;
    vcount_in = 0; hcount_in = 0;
    vsync_in = 0; hsync_in = 0; vblnk_in = 0; hblnk_in = 0;
    rgb_in = 0;
  endtask

  task automatic frame_tick();
    vblnk_in = 1; step(); step();
    vblnk_in = 0; step(); step();
  endtask

  task automatic do_launch(input logic [11:0] lx, input logic [11:0] ly);
    launch = 1; launch_x = lx; launch_y = ly;
    step();
    launch = 0; launch_x = 0; launch_y = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    vcount_in = 11'd300; hcount_in = 11'd400; vsync_in = 1; hsync_in = 1;
    vblnk_in = 1; hblnk_in = 1; rgb_in = 12'hABC;
    step(); step(); step(); step();
    n_total++;
    if (rgb_out !== 12'h000) $display("FAIL reset_rgb: got %h expected 000", rgb_out); else n_pass++;
    n_total++;
    if (rom_addr !== 12'h000) $display("FAIL reset_rom_addr: got %h expected 000", rom_addr); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++;
    if ({vcount_out, hcount_out} !== 22'd0)
      $display("FAIL reset_counts: got v=%0d h=%0d expected 0 0", vcount_out, hcount_out);
    else n_pass++;
    n_total++;
    if ({vsync_out, hsync_out, vblnk_out, hblnk_out} !== 4'b0000)
      $display("FAIL reset_sync: got %b expected 0000", {vsync_out, hsync_out, vblnk_out, hblnk_out});
    else n_pass++;
    rst = 0;
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_passthrough();
    rgb_in = 12'h123; hcount_in = 11'd5; vcount_in = 11'd7; vsync_in = 1; hsync_in = 1;
    step();
    n_total++;
    if (rgb_out !== 12'h000) $display("FAIL pass_early: got %h expected 000", rgb_out); else n_pass++;
    rgb_in = 12'h456; hcount_in = 11'd6; vsync_in = 0; hsync_in = 0;
    step();
    n_total++;
    if (rgb_out !== 12'h000) $display("FAIL pass_lat2: got %h expected 000", rgb_out); else n_pass++;
    rgb_in = 12'h789; hcount_in = 11'd7;
    step();
    n_total++;
    if (rgb_out !== 12'h123) $display("FAIL pass_lat3_rgb: got %h expected 123", rgb_out); else n_pass++;
    n_total++;
    if (hcount_out !== 11'd5 || vcount_out !== 11'd7 || vsync_out !== 1'b1 || hsync_out !== 1'b1)
      $display("FAIL pass_lat3_timing: got h=%0d v=%0d vs=%b hs=%b expected 5 7 1 1",
               hcount_out, vcount_out, vsync_out, hsync_out);
    else n_pass++;
    idle_inputs();
    step();
    n_total++;
    if (rgb_out !== 12'h456 || hcount_out !== 11'd6) $display("FAIL pass_next: got %h/%0d expected 456/6", rgb_out, hcount_out); else n_pass++;
    n_total++;
    if (rom_addr !== 12'h000) $display("FAIL idle_rom_addr: got %h expected 000", rom_addr); else n_pass++;
    step(); step();
  endtask

  task automatic probe(input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] exp_addr, input string name);
    hcount_in = h; vcount_in = v;
    step();
    n_total++;
    if (rom_addr !== exp_addr) $display("FAIL %s: rom_addr got %h expected %h", name, rom_addr, exp_addr); else n_pass++;
    hcount_in = 0; vcount_in = 0;
  endtask

  task automatic test_launch_overlay();
    do_launch(12'd100, 12'd200);
    n_total++;
    if (busy !== 1'b1) $display("FAIL launch_busy: got %b expected 1", busy); else n_pass++;
    hcount_in = 11'd110; vcount_in = 11'd205; rgb_in = 12'h0F0;
    step();
    n_total++;
    if (rom_addr !== 12'h14A) $display("FAIL launch_addr: got %h expected 14A", rom_addr); else n_pass++;
    hcount_in = 11'd100; vcount_in = 11'd215; rgb_in = 12'h0F1;
    step();
    n_total++;
    if (rom_addr !== 12'h3C0) $display("FAIL launch_addr2: got %h expected 3C0", rom_addr); else n_pass++;
    hcount_in = 11'd50; vcount_in = 11'd0; rgb_in = 12'h0F2;
    step();
    n_total++;
    if (rgb_out !== 12'h94A) $display("FAIL overlay_drawn: got %h expected 94A", rgb_out); else n_pass++;
    n_total++;
    if (rom_addr !== 12'h000) $display("FAIL miss_addr: got %h expected 000", rom_addr); else n_pass++;
    idle_inputs();
    step();
    n_total++;
    if (rgb_out !== 12'h0F1) $display("FAIL overlay_transparent: got %h expected 0F1", rgb_out); else n_pass++;
    step();
    n_total++;
    if (rgb_out !== 12'h0F2) $display("FAIL overlay_miss: got %h expected 0F2", rgb_out); else n_pass++;
    // Hit pixel during horizontal blanking must pass through untouched.
    hcount_in = 11'd110; vcount_in = 11'd205; hblnk_in = 1; rgb_in = 12'h0F3;
    step();
    idle_inputs();
    step(); step();
    n_total++;
    if (rgb_out !== 12'h0F3 || hblnk_out !== 1'b1 || hcount_out !== 11'd110)
      $display("FAIL blank_pass: got rgb=%h hb=%b h=%0d expected 0F3 1 110", rgb_out, hblnk_out, hcount_out);
    else n_pass++;
    step(); step();
  endtask

  task automatic test_motion_lifetime();
    frame_tick();
    probe(11'd113, 11'd201, 12'h14A, "motion_tick1");
    probe(11'd112, 11'd201, 12'h149, "motion_tick1_col");
    n_total++;
    if (b_busy !== 1'b1) $display("FAIL short_busy_t1: got %b expected 1", b_busy); else n_pass++;
    frame_tick();
    do_launch(12'd300, 12'd300);   // both instances busy: ignored
    frame_tick();
    n_total++;
    if (b_busy !== 1'b1) $display("FAIL short_busy_t3: got %b expected 1", b_busy); else n_pass++;
    frame_tick();
    n_total++;
    if (b_busy !== 1'b0) $display("FAIL short_busy_t4: got %b expected 0", b_busy); else n_pass++;
    for (int i = 5; i <= 10; i++) frame_tick();
    n_total++;
    if (busy !== 1'b1) $display("FAIL long_busy_t10: got %b expected 1", busy); else n_pass++;
    probe(11'd140, 11'd165, 12'h14A, "motion_tick10");
    do_launch(12'd0, 12'd0);
    n_total++;
    if (b_busy !== 1'b1) $display("FAIL short_relaunch: got %b expected 1", b_busy); else n_pass++;
    probe(11'd140, 11'd165, 12'h14A, "long_ignores_launch");
  endtask

  task automatic test_reset_midflight();
    rst = 1; rgb_in = 12'hFFF; hcount_in = 11'd140; vcount_in = 11'd165;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else n_pass++;
    n_total++;
    if (rgb_out !== 12'h000) $display("FAIL midreset_rgb: got %h expected 000", rgb_out); else n_pass++;
    rst = 0;
    idle_inputs();
    rgb_in = 12'h321;
    step();
    n_total++;
    if (rgb_out !== 12'h000) $display("FAIL midreset_flush: got %h expected 000", rgb_out); else n_pass++;
    rgb_in = 12'h654;
    step();
    rgb_in = 12'h000;
    step();
    n_total++;
    if (rgb_out !== 12'h321) $display("FAIL midreset_resume: got %h expected 321", rgb_out); else n_pass++;
    step(); step(); step();
  endtask

  task automatic test_edge_kill();
    do_launch(12'd798, 12'd10);
    n_total++;
    if (busy !== 1'b1) $display("FAIL edge_busy: got %b expected 1", busy); else n_pass++;
    probe(11'd799, 11'd10, 12'h001, "edge_visible_col");
    // Column past the active area falls in blanking: not drawn.
    hcount_in = 11'd805; vcount_in = 11'd10; hblnk_in = 1; rgb_in = 12'h0A0;
    step();
    idle_inputs();
    step(); step();
    n_total++;
    if (rgb_out !== 12'h0A0) $display("FAIL edge_past_800: got %h expected 0A0", rgb_out); else n_pass++;
    frame_tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL edge_kill_busy: got %b expected 0", busy); else n_pass++;
    n_total++;
    if (dut.u_motion.x !== 12'd798) $display("FAIL edge_kill_x: got %0d expected 798", dut.u_motion.x); else n_pass++;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_launch_overlay();
    test_motion_lifetime();
    test_reset_midflight();
    test_edge_kill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
